// File: rtl/mdu_seq_if.sv
// Handshake and adder-port bundle for the mdu_seq multiply/divide sequencer.
// The slave modport is the sequencer; the master is the requester plus the external adder.
interface mdu_seq_if;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_sub;
  logic [31:0] add_s;
  logic        add_co;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  modport slave (
    input  start, op, opa, opb, add_s, add_co,
    output add_a, add_b, add_sub, busy, done, hi, lo, err
  );

  modport master (
    output start, op, opa, opb, add_s, add_co,
    input  add_a, add_b, add_sub, busy, done, hi, lo, err
  );
endinterface

// File: rtl/mdu_seq.sv
// 32-iteration unsigned multiply/divide sequencer driving one external add/sub unit.
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mdu_seq (
  input  logic     clk,
  input  logic     rst_n,
  mdu_seq_if.slave bus
);

`ifdef MDU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_m;
  logic [4:0]  r_cnt;
  logic        r_err;

  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_add_sub;
  logic        w_accept;

`ifdef MDU_DIV_EN
  logic [31:0] w_sh;
  logic        w_ge;

  // Restoring step: a set hi[31] means the shifted remainder already exceeds 2^32 > m.
  assign w_sh = {r_hi[30:0], r_lo[31]};
  assign w_ge = r_hi[31] | bus.add_co;
`endif

  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);

  // NOTE: every path assigns a default first, so no latch is inferred for idle states.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_sub = 1'b0;
    case (r_state)
      S_MUL: begin
        w_add_a = r_hi;
        w_add_b = r_m;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        w_add_a   = w_sh;
        w_add_b   = r_m;
        w_add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_cnt <= '0;
            r_err <= 1'b0;
            r_m   <= bus.opb;
            if (!bus.op) begin
              r_hi    <= '0;
              r_lo    <= bus.opa;
              r_state <= S_MUL;
            end else begin
`ifdef MDU_DIV_EN
              if (bus.opb == 32'd0) begin
                r_hi    <= bus.opa;
                r_lo    <= '1;
                r_err   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_hi    <= '0;
                r_lo    <= bus.opa;
                r_state <= S_DIV;
              end
`else
              r_hi    <= '0;
              r_lo    <= '0;
              r_err   <= 1'b1;
              r_state <= S_DONE;
`endif
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_MUL: begin
          // Shift-add: the 33-bit partial sum drops into hi, the multiplier shifts out of lo.
          if (r_lo[0]) begin
            {r_hi, r_lo} <= {bus.add_co, bus.add_s, r_lo[31:1]};
          end else begin
            {r_hi, r_lo} <= {1'b0, r_hi, r_lo[31:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
          end
        end

`ifdef MDU_DIV_EN
        S_DIV: begin
          r_hi  <= w_ge ? bus.add_s : w_sh;
          r_lo  <= {r_lo[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.add_a   = w_add_a;
  assign bus.add_b   = w_add_b;
  assign bus.add_sub = w_add_sub;
`ifdef MDU_DIV_EN
  assign bus.busy    = (r_state == S_MUL) || (r_state == S_DIV);
`else
  assign bus.busy    = (r_state == S_MUL);
`endif
  assign bus.done    = (r_state == S_DONE);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq; models the external adder and checks
// results, latency, busy width, handshake corner cases and mid-operation reset.
module tb_mdu_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mdu_seq_if bus ();

  mdu_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational adder: subtract is A + ~B + 1, carry-out = no borrow.
  logic [32:0] w_sum;
  assign w_sum = bus.add_sub ? ({1'b0, bus.add_a} + {1'b0, ~bus.add_b} + 33'd1)
                             : ({1'b0, bus.add_a} + {1'b0, bus.add_b});
  assign bus.add_s  = w_sum[31:0];
  assign bus.add_co = w_sum[32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic op_i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at the first negedge after the start edge; returns at the done negedge.
  task automatic wait_done(input bit glitch, output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      bus.start = glitch && (lat == 5 || lat == 20);
      if (glitch) begin
        bus.op  = 1'b1;
        bus.opa = 32'd9999;
        bus.opb = 32'd3;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("done_seen", {63'd0, bus.done}, 64'd1);
  endtask

  task automatic run_check(input string tag, input logic op_i,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic exp_err, input int exp_lat);
    int lat;
    int bcnt;
    launch(op_i, a, b);
    wait_done(1'b0, lat, bcnt);
    check({tag, "_hi"},   {32'd0, bus.hi}, {32'd0, exp_hi});
    check({tag, "_lo"},   {32'd0, bus.lo}, {32'd0, exp_lo});
    check({tag, "_err"},  {63'd0, bus.err}, {63'd0, exp_err});
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(bcnt), (exp_lat == 33) ? 64'd32 : 64'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int seen;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {63'd0, bus.busy}, 64'd0);
    check("rst_done",  {63'd0, bus.done}, 64'd0);
    check("rst_hilo",  {bus.hi, bus.lo}, 64'd0);
    check("rst_err",   {63'd0, bus.err}, 64'd0);
    check("rst_add",   {bus.add_a, bus.add_b}, 64'd0);
    rst_n = 1'b1;

    run_check("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33);
    check("done_addsub", {63'd0, bus.add_sub}, 64'd0);
    @(negedge clk);
    check("done_pulse", {62'd0, bus.done, bus.busy}, 64'd0);
    check("hold_lo", {32'd0, bus.lo}, 64'd42);

    run_check("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    run_check("mul_msb", 1'b0, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0, 33);

`ifdef MDU_DIV_EN
    run_check("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run_check("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    run_check("div_5_9",   1'b1, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 33);
    run_check("div_by0",   1'b1, 32'd123, 32'd0, 32'd123, 32'hFFFF_FFFF, 1'b1, 1);
`else
    run_check("div_off_a", 1'b1, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 1);
    run_check("div_off_b", 1'b1, 32'd123, 32'd0, 32'd0, 32'd0, 1'b1, 1);
`endif

    // Stray start pulses mid-operation must leave the multiply untouched.
    launch(1'b0, 32'd7, 32'd6);
    wait_done(1'b1, lat, bcnt);
    check("glitch_lo",  {bus.hi, bus.lo}, 64'd42);
    check("glitch_lat", 64'(lat), 64'd33);

    // Back-to-back: a start during the DONE cycle launches the next multiply.
    launch(1'b0, 32'd1000, 32'd1000);
    wait_done(1'b0, lat, bcnt);
    check("b2b_first", {bus.hi, bus.lo}, 64'd1000000);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.opa   = 32'd3;
    bus.opb   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_handoff", {62'd0, bus.done, bus.busy}, 64'd1);
    wait_done(1'b0, lat, bcnt);
    check("b2b_second", {bus.hi, bus.lo}, 64'd15);
    check("b2b_lat",    64'(lat), 64'd33);

    // Asynchronous reset in the middle of a multiply.
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midrst_ctl",  {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
    check("midrst_add",  {bus.add_a, bus.add_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("midrst_quiet", 64'(seen), 64'd0);

    run_check("mul_after_rst", 1'b0, 32'd12345, 32'd10, 32'd0, 32'd123450, 1'b0, 33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
